// File: rtl/simon_round_seq.sv
// Round sequencer for a single-round SimonCore (SIMON 64/128): requests key expansion,
// then runs ROUNDS core handshakes per 64-bit block between the in/out block handshakes.
//
// state    | meaning
// ST_IDLE  | no expanded key; waiting for key_load
// ST_KREQ  | one-cycle key expansion request to the core
// ST_KWAIT | waiting for the core to report key expansion done
// ST_READY | key valid; accepting a block or a key reload
// ST_ISSUE | presenting the current words to the core
// ST_WAIT  | waiting for the core's round result
// ST_OUT   | presenting the finished block downstream
module simon_round_seq #(
  parameter int ROUNDS = 44,
  parameter int RCW    = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_load,
  output logic        key_ready,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic        in_dec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        core_kvalid,
  input  logic        core_kdone,
  output logic [63:0] core_data1,
  output logic [63:0] core_data2,
  input  logic [63:0] core_res1,
  input  logic [63:0] core_res2,
  output logic        core_valid,
  input  logic        core_ready,
  input  logic        core_done,
  output logic        core_encdec,
  output logic        core_single
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KREQ,
    ST_KWAIT,
    ST_READY,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [63:0]      d1;
  logic [63:0]      d2;
  logic [RCW-1:0]   cnt;
  logic [RCW-1:0]   cnt_dec;
  logic             encdec;

  assign cnt_dec = cnt - RCW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (key_load) state_nxt = ST_KREQ;
      ST_KREQ:  state_nxt = ST_KWAIT;
      ST_KWAIT: if (core_kdone) state_nxt = ST_READY;
      // a block request wins over a simultaneous key reload
      ST_READY: begin
        if (in_valid)      state_nxt = ST_ISSUE;
        else if (key_load) state_nxt = ST_KREQ;
      end
      ST_ISSUE: if (core_ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_done) state_nxt = (cnt_dec == '0) ? ST_OUT : ST_ISSUE;
      end
      ST_OUT:   if (out_ready) state_nxt = ST_READY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Flag outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      d1          <= '0;
      d2          <= '0;
      cnt         <= '0;
      encdec      <= 1'b0;
      key_ready   <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      core_kvalid <= 1'b0;
      core_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_ready   <= (state_nxt == ST_READY) || (state_nxt == ST_ISSUE) ||
                     (state_nxt == ST_WAIT)  || (state_nxt == ST_OUT);
      in_ready    <= (state_nxt == ST_READY);
      out_valid   <= (state_nxt == ST_OUT);
      core_kvalid <= (state_nxt == ST_KREQ);
      core_valid  <= (state_nxt == ST_ISSUE);

      if (state == ST_READY && in_valid) begin
        d1     <= {32'b0, in_block[31:0]};
        d2     <= {32'b0, in_block[63:32]};
        encdec <= ~in_dec;
        cnt    <= RCW'(ROUNDS);
      end

      if (state == ST_WAIT && core_done) begin
        d1  <= core_res1;
        d2  <= core_res2;
        cnt <= cnt_dec;
      end
    end
  end

  // The core only uses the low word of each data input, so the upper halves are dropped here.
  assign out_block   = {d2[31:0], d1[31:0]};
  assign core_data1  = d1;
  assign core_data2  = d2;
  assign core_encdec = encdec;
  assign core_single = 1'b1;

endmodule

// File: tb/tb_simon_round_seq.sv
// Bench for simon_round_seq: a behavioural SimonCore stand-in plus a block-level SIMON 64/128
// reference supply expected results; a per-cycle compare process checks the sequencer.
module tb_simon_round_seq;

  localparam int ROUNDS = 44;
  localparam int RCW    = 6;

  localparam logic [127:0] K_SPEC = 128'h56AB09BBA4F930110042AA2AFF020180;
  localparam logic [127:0] K_NSA  = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT     = 64'h0706050403020100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_load = 1'b0;
  logic        key_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_block = '0;
  logic        in_dec = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_block;
  logic        core_kvalid;
  logic        core_kdone = 1'b0;
  logic [63:0] core_data1;
  logic [63:0] core_data2;
  logic [63:0] core_res1 = '0;
  logic [63:0] core_res2 = '0;
  logic        core_valid;
  logic        core_ready = 1'b1;
  logic        core_done = 1'b0;
  logic        core_encdec;
  logic        core_single;

  simon_round_seq #(.ROUNDS(ROUNDS), .RCW(RCW)) dut (
    .clock(clock), .reset(reset),
    .key_load(key_load), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .core_kvalid(core_kvalid), .core_kdone(core_kdone),
    .core_data1(core_data1), .core_data2(core_data2),
    .core_res1(core_res1), .core_res2(core_res2),
    .core_valid(core_valid), .core_ready(core_ready), .core_done(core_done),
    .core_encdec(core_encdec), .core_single(core_single)
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- SIMON 64/128 reference ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
    return (v >> s) | (v << (32 - s));
  endfunction

  function automatic logic [31:0] f_simon(input logic [31:0] x);
    return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
  endfunction

  function automatic logic [31:0] round_key(input logic [127:0] key, input int idx);
    logic [31:0] k [0:ROUNDS-1];
    logic [63:0] z;
    z = 64'hfc2ce51207a635db;
    for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
    for (int i = 4; i < ROUNDS; i++)
      k[i] = 32'hfffffffc ^ {31'b0, z[i-4]} ^ k[i-4] ^ rotr(k[i-1], 3) ^ k[i-3] ^
             rotr(k[i-1], 4) ^ rotr(k[i-3], 1);
    return k[idx];
  endfunction

  function automatic logic [63:0] ref_crypt(input logic [63:0] blk, input logic [127:0] key,
                                            input logic dec);
    logic [31:0] x, y, t;
    x = blk[63:32];
    y = blk[31:0];
    for (int r = 0; r < ROUNDS; r++) begin
      if (!dec) begin
        t = x; x = y ^ f_simon(x) ^ round_key(key, r); y = t;
      end else begin
        t = y; y = x ^ f_simon(y) ^ round_key(key, ROUNDS - 1 - r); x = t;
      end
    end
    return {x, y};
  endfunction

  // ---------------- SimonCore stand-in ----------------
  logic [127:0] core_key = '0;
  logic [127:0] exp_key  = '0;
  int           kv_pulses = 0;
  int           hs_count = 0;
  int           stall = 0;
  bit           spurious_req = 0;

  initial begin : core_model
    int          kcnt;
    int          rnd;
    bit          hs_pending;
    bit          prev_stall;
    logic [63:0] cap1, cap2, prev_d1, prev_d2;
    logic        cap_enc;
    logic [31:0] x, y, nx, ny;
    kcnt = 0; rnd = 0; hs_pending = 0; prev_stall = 0;
    cap1 = '0; cap2 = '0; prev_d1 = '0; prev_d2 = '0; cap_enc = 1'b0;
    forever begin
      @(negedge clock); #2;
      if (!reset) begin
        core_done = 0; core_kdone = 0; core_ready = 1;
        hs_pending = 0; kcnt = 0; rnd = 0; stall = 0; spurious_req = 0; prev_stall = 0;
      end else begin
        core_done = 0;
        if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) core_kdone = 1;
        end
        if (core_kvalid) begin
          kv_pulses++; exp_key = core_key; core_kdone = 0; kcnt = 3; rnd = 0;
        end
        if (hs_pending) begin
          x = cap2[31:0];
          y = cap1[31:0];
          if (cap_enc) begin
            nx = y ^ f_simon(x) ^ round_key(exp_key, rnd); ny = x;
          end else begin
            ny = x ^ f_simon(y) ^ round_key(exp_key, ROUNDS - 1 - rnd); nx = y;
          end
          // garbage in the upper halves must never reach out_block
          core_res1 = {$urandom, ny};
          core_res2 = {$urandom, nx};
          core_done = 1;
          rnd = (rnd + 1) % ROUNDS;
          hs_pending = 0;
        end else if (spurious_req && core_valid) begin
          core_res1 = {$urandom, $urandom};
          core_res2 = {$urandom, $urandom};
          core_done = 1;
          spurious_req = 0;
        end
        if (stall > 0) begin core_ready = 0; stall--; end
        else core_ready = 1;
        if (prev_stall) begin
          chk("issue_valid_hold", core_valid, 1);
          chk("issue_data1_hold", core_data1, prev_d1);
          chk("issue_data2_hold", core_data2, prev_d2);
        end
        prev_stall = core_valid && !core_ready;
        prev_d1 = core_data1;
        prev_d2 = core_data2;
        if (core_valid && core_ready) begin
          hs_pending = 1; cap1 = core_data1; cap2 = core_data2; cap_enc = core_encdec;
          hs_count++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0] exp_q [$];
  logic [63:0] last_out = '0;
  logic        exp_enc = 1'b0;
  bit          busy = 0;
  int          out_count = 0;

  initial begin : compare
    forever begin
      @(negedge clock); #3;
      chk("core_single", core_single, 1);
      if (!reset) begin
        chk("rst_flags", {key_ready, in_ready, out_valid, core_kvalid, core_valid, core_encdec}, 0);
        chk("rst_out_block", out_block, 0);
        chk("rst_core_data", core_data1 | core_data2, 0);
        exp_q.delete(); busy = 0; hs_count = 0;
      end else begin
        if (busy) begin
          chk("busy_in_ready", in_ready, 0);
          chk("busy_key_ready", key_ready, 1);
          chk("busy_kvalid", core_kvalid, 0);
        end
        if (core_valid) chk("core_encdec", core_encdec, exp_enc);
        if (out_valid) begin
          chk("out_expected", busy, 1);
          chk("out_core_idle", core_valid, 0);
          chk("round_count", hs_count, ROUNDS);
          if (exp_q.size() > 0) chk("out_block", out_block, exp_q[0]);
          if (out_ready) begin
            last_out = out_block;
            out_count++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            busy = 0;
          end
        end
        if (in_valid && in_ready) begin
          busy = 1; hs_count = 0; exp_enc = ~in_dec;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_key(input logic [127:0] key);
    int kv0;
    bit ok;
    core_key = key;
    kv0 = kv_pulses;
    @(negedge clock); key_load = 1;
    @(negedge clock); key_load = 0;
    @(negedge clock); #4;
    chk("key_busy", key_ready, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); #4;
      if (key_ready) begin ok = 1; break; end
    end
    chk("key_ready", key_ready, 1);
    chk("kvalid_pulses", kv_pulses - kv0, 1);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock); #4;
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send_block(input logic [63:0] blk, input logic dec, input logic [127:0] key);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      exp_q.push_back(ref_crypt(blk, key, dec));
      @(negedge clock); in_valid = 1; in_block = blk; in_dec = dec;
      @(negedge clock); in_valid = 0;
    end
  endtask

  task automatic wait_out(input string name);
    int oc0;
    bit done;
    oc0 = out_count;
    done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock); #4;
      if (out_count != oc0) begin done = 1; break; end
    end
    if (!done) $display("FAIL %s: no out_valid handshake within bound", name);
    chk("out_seen", done, 1);
    repeat (4) @(negedge clock);
    #4 chk("out_single_pulse", out_count - oc0, 1);
  endtask

  task automatic wait_rounds(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #4;
      if (hs_count >= n) break;
    end
    chk("reach_round", hs_count >= n, 1);
  endtask

  initial begin : stim
    logic [63:0] ct, rec;
    int          kv0, oc0;
    bit          ok;

    // model pins against hand-known values
    chk("pin_f", f_simon(32'h00000001), 64'h4);
    chk("pin_kat_enc", ref_crypt(64'h656b696c20646e75, K_NSA, 0), 64'h44c8fc20b9dfa07a);
    chk("pin_kat_dec", ref_crypt(64'h44c8fc20b9dfa07a, K_NSA, 1), 64'h656b696c20646e75);

    repeat (3) @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    #4 chk("idle_flags", {key_ready, in_ready, out_valid}, 0);

    load_key(K_SPEC);

    ct = ref_crypt(PT, K_SPEC, 0);
    send_block(PT, 0, K_SPEC);
    wait_out("encrypt");
    chk("enc_result", last_out, ct);
    send_block(ct, 1, K_SPEC);
    wait_out("decrypt");
    chk("dec_roundtrip", last_out, 64'h0706050403020100);

    // downstream backpressure in OUT
    out_ready = 0;
    send_block(64'h0123456789abcdef, 0, K_SPEC);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #4;
      if (out_valid) break;
    end
    chk("bp_out_seen", out_valid, 1);
    rec = out_block;
    repeat (20) begin
      @(negedge clock); #4;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_stable", out_block, rec);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_core_idle", core_valid, 0);
    end
    @(negedge clock); out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #4;
      if (in_ready) break;
    end
    chk("bp_release", in_ready, 1);

    // in_valid and key_load together in READY
    wait_ready(ok);
    kv0 = kv_pulses;
    exp_q.push_back(ref_crypt(64'hdeadbeefcafef00d, K_SPEC, 0));
    @(negedge clock); in_valid = 1; key_load = 1; in_block = 64'hdeadbeefcafef00d; in_dec = 0;
    @(negedge clock); in_valid = 0; key_load = 0;
    wait_out("priority");
    chk("priority_no_kexp", kv_pulses - kv0, 0);

    // spurious core_done in ISSUE and core_ready stall
    send_block(64'h1122334455667788, 1, K_SPEC);
    wait_rounds(3);
    stall = 5;
    spurious_req = 1;
    wait_out("stall");
    chk("spurious_injected", spurious_req, 0);

    // known-answer vector through the DUT
    load_key(K_NSA);
    send_block(64'h656b696c20646e75, 0, K_NSA);
    wait_out("kat");
    chk("kat_dut", last_out, 64'h44c8fc20b9dfa07a);

    // reset in the middle of a block
    send_block(64'hf0e1d2c3b4a59687, 0, K_NSA);
    wait_rounds(10);
    @(negedge clock); #1 reset = 0;
    #1;
    chk("midrst_flags", {key_ready, in_ready, out_valid, core_kvalid, core_valid, core_encdec}, 0);
    chk("midrst_out_block", out_block, 0);
    chk("midrst_core_data", core_data1 | core_data2, 0);
    chk("midrst_single", core_single, 1);
    repeat (3) @(negedge clock);
    reset = 1;
    oc0 = out_count;
    repeat (10) @(negedge clock);
    #4;
    chk("midrst_no_out", out_count - oc0, 0);
    chk("midrst_key_lost", {key_ready, in_ready}, 0);
    load_key(K_SPEC);
    send_block(PT, 0, K_SPEC);
    wait_out("after_reset");
    chk("after_reset_result", last_out, ct);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule
